bram_sync_fifo: RTL and testbench
=================================

# bram_sync_fifo

Single-clock synchronous FIFO built on one TDP36K block in simple-dual-port configuration, parametrised in data width (1–36 bits, including 9/18/36-bit parity widths) and depth. It adds what the plain BRAM mappings lack: pointer management, full/empty/almost flags, occupancy count, an optional output register and sticky error flags. It is the standard buffering primitive for qlf_k6n10f designs that need deep FIFOs without fabric flops.

## Interface
- DATA_WIDTH, 18: word width. Legal values are 1, 2, 4, 8, 9, 16, 18, 32 and 36; any other value is an elaboration error.
- ADDR_WIDTH, 10: log2 of depth. DATA_WIDTH·2^ADDR_WIDTH must not exceed 36864; otherwise elaboration error.
- AFULL_THRESH, 2^ADDR_WIDTH-4: AFULL_O asserts when count ≥ this value.
- AEMPTY_THRESH, 4: AEMPTY_O asserts when count ≤ this value.
- OUT_REG, 0: 1 adds an output register stage, giving read latency 2.
- CLK_i  in  1  single clock; all logic rises on it.
- RST_i  in  1  synchronous, active-high reset.
- FLUSH_i  in  1  synchronous clear of FIFO contents (pointers/count).
- PUSH_i  in  1  write request.
- WDATA_i  in  DATA_WIDTH  write data.
- POP_i  in  1  read request.
- RDATA_o  out  DATA_WIDTH  read data.
- RVALID_o  out  1  RDATA_o valid this cycle.
- FULL_o, EMPTY_o, AFULL_o, AEMPTY_o  out  1 each  status flags.
- COUNT_o  out  ADDR_WIDTH+1  occupancy.
- OVERFLOW_o, UNDERFLOW_o  out  1 each  sticky error flags.

## Operation
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo 2^ADDR_WIDTH. A separate count register is ADDR_WIDTH+1 bits.
- EMPTY_o is (count==0). FULL_o is (count==2^ADDR_WIDTH).
- All flags and COUNT_o decode registered state only. There is no combinational path from PUSH_i or POP_i to any output.
- Push acceptance: push_ok = PUSH_i & !FULL_o. A push while full is dropped and sets OVERFLOW_o. This holds even when POP_i is asserted in the same cycle.
- Pop acceptance: pop_ok = POP_i & !EMPTY_o. A pop while empty is dropped and sets UNDERFLOW_o. There is no write-to-read bypass: a simultaneous push into an empty FIFO is accepted, and the pop is rejected.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Priority order: RST_i, then FLUSH_i, then push/pop.
- FLUSH_i clears pointers and count and squashes any in-flight RVALID. It leaves OVERFLOW_o and UNDERFLOW_o intact. Push and pop in the same cycle as FLUSH_i are ignored and raise no error flags.
- Physical mapping:
  - Physical address = logical address << shift(DATA_WIDTH), with shift 0/1/2/3/4/5 for widths 1/2/4/8–9/16–18/32–36.
  - In 9-bit mode, bit 8 is stored in physical lane bit 16.
  - In 18-bit mode, bits 17:16 are the parity lanes.
- Reads and writes never target the same unread location, so read-during-write behaviour is don't-care.
- RAM contents are not initialised by reset or flush.

## Timing
- Reset values: COUNT_o=0, EMPTY_o=1, AEMPTY_o=1, FULL_o=0, AFULL_o=0, RVALID_o=0, RDATA_o=0, OVERFLOW_o=0, UNDERFLOW_o=0.
- Push accepted at edge N: COUNT_o and the flags update after edge N. The earliest pop of that word is accepted at edge N+1.
- Read latency: a pop accepted at edge N gives RVALID_o=1 with data after edge N+1+OUT_REG. RVALID_o is high for exactly one cycle per accepted pop.
- RDATA_o holds its last value while RVALID_o=0.
- Back-to-back pops sustain one word per cycle.
- Reset or flush asserted mid-stream drops all pending RVALID pulses from the next edge.
- Sticky flags clear only on RST_i.

## Structure
- Package qlf_bram_pkg holds:
  - mode encodings MODE_1/2/4/9/18/36;
  - the functions addr_shift(width) and mode_of(width);
  - the legal-width check function.
- Sub-module bram_sdp_core: one write port, one registered read port, physical address/lane packing, and the TDP36K-compatible MODE_BITS. bram_sync_fifo contains only control logic plus this core.

## Test plan
- DATA_WIDTH=18, ADDR_WIDTH=4: push 16 words 0x00001..0x00010 → FULL_o=1 and COUNT_o=16. A 17th push sets OVERFLOW_o=1 and COUNT_o stays 16.
- Then pop 16 words → RDATA_o returns 0x00001..0x00010 in order, RVALID_o one cycle after each pop (OUT_REG=0). EMPTY_o=1 after the last pop. One extra pop sets UNDERFLOW_o=1.
- DATA_WIDTH=9: push 0x1A5 and 0x05A, then pop both → RDATA_o=0x1A5 then 0x05A, so bit 8 survives via lane 16. OUT_REG=1 gives latency 2.
- Simultaneous PUSH_i/POP_i at count=5 for 100 cycles → COUNT_o stays 5 and data order is preserved. At count=0, the simultaneous pair gives COUNT_o=1 and no RVALID_o.
- AFULL/AEMPTY with ADDR_WIDTH=4 and defaults: count 4 → AEMPTY_O=1; count 5 → 0; count 12 → AFULL_O=1; count 11 → 0.
- FLUSH_i asserted with count=7, a pop in flight, and OVERFLOW_o=1 → next cycle COUNT_o=0, EMPTY_o=1, no RVALID_o, OVERFLOW_o still 1. RST_i then clears OVERFLOW_o.

Source files
------------

// File: rtl/qlf_bram_pkg.sv
// qlf_bram_pkg
// Shared definitions for TDP36K-based memories: the width-mode encodings
// written into the block's MODE_BITS, plus constant functions that map a
// logical word width onto its physical mode, address shift and legality.
// No ports; imported by bram_sdp_core and bram_sync_fifo.
package qlf_bram_pkg;

  // Port width modes as the TDP36K primitive encodes them.
  typedef enum logic [2:0] {
    MODE_1  = 3'b101,
    MODE_2  = 3'b110,
    MODE_4  = 3'b100,
    MODE_9  = 3'b001,
    MODE_18 = 3'b010,
    MODE_36 = 3'b011
  } mode_t;

  localparam int BRAM_BITS = 36864;

  // Widths the block can natively hold; 8/16/32 ride in the parity-capable modes.
  function automatic bit legal_width(input int width);
    case (width)
      1, 2, 4, 8, 9, 16, 18, 32, 36: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // The physical address is always in 1-bit units, so each logical word
  // address is shifted left by log2 of the lane width it occupies.
  function automatic int addr_shift(input int width);
    case (width)
      1:       return 0;
      2:       return 1;
      4:       return 2;
      8, 9:    return 3;
      16, 18:  return 4;
      default: return 5;
    endcase
  endfunction

  function automatic mode_t mode_of(input int width);
    case (width)
      1:       return MODE_1;
      2:       return MODE_2;
      4:       return MODE_4;
      8, 9:    return MODE_9;
      16, 18:  return MODE_18;
      default: return MODE_36;
    endcase
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// bram_sdp_core
// Simple-dual-port view of one TDP36K: a write port and a registered read
// port. Logical addresses are converted to bit-granular physical addresses
// and data is packed onto the physical lanes the way the primitive expects.
// Ports:
//   clk_i               clock
//   we_i, waddr_i, wdata_i   write enable / logical address / data
//   re_i, raddr_i            read enable / logical address
//   rdata_o             read data, updated on the edge that samples re_i
module bram_sdp_core
  import qlf_bram_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int          SHIFT     = addr_shift(DATA_WIDTH);
  localparam int          PA_W      = ADDR_WIDTH + SHIFT;
  localparam int          LANE_W    = (DATA_WIDTH > 18) ? 36 : 18;
  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam mode_t       MODE      = mode_of(DATA_WIDTH);
  // Read and write halves of the primitive always share one width here.
  localparam logic [5:0]  MODE_BITS = {MODE, MODE};

  logic [PA_W-1:0]       wpa, rpa;
  logic [ADDR_WIDTH-1:0] widx, ridx;
  logic [LANE_W-1:0]     wlane;
  logic [LANE_W-1:0]     mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Physical addresses as the primitive sees them; the array row is the
  // same address with the intra-row bit offset stripped back off.
  assign wpa  = PA_W'(waddr_i) << SHIFT;
  assign rpa  = PA_W'(raddr_i) << SHIFT;
  assign widx = ADDR_WIDTH'(wpa >> SHIFT);
  assign ridx = ADDR_WIDTH'(rpa >> SHIFT);

  always_ff @(posedge clk_i) begin
    if (we_i) mem[widx] <= wlane;
  end

  // x9 keeps its ninth bit in the parity lane at bit 16; every other width
  // is a straight right-aligned placement.
  if ((MODE_BITS[2:0] == MODE_9) && (DATA_WIDTH == 9)) begin : g_x9
    assign wlane = {1'b0, wdata_i[8], 8'h00, wdata_i[7:0]};
    always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= {mem[ridx][16], mem[ridx][7:0]};
    end
  end else begin : g_plain
    assign wlane = LANE_W'(wdata_i);
    always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem[ridx][DATA_WIDTH-1:0];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_sync_fifo.sv
// bram_sync_fifo
// Single-clock FIFO on one TDP36K: pointer/count management, status flags,
// sticky error flags and an optional output register around bram_sdp_core.
// Ports:
//   CLK_i, RST_i (sync, active high), FLUSH_i (sync content clear)
//   PUSH_i/WDATA_i write side, POP_i read request
//   RDATA_o/RVALID_o read data, valid for one cycle per accepted pop
//   FULL_o, EMPTY_o, AFULL_o, AEMPTY_o, COUNT_o status from registered state
//   OVERFLOW_o, UNDERFLOW_o sticky errors, cleared only by RST_i
module bram_sync_fifo
  import qlf_bram_pkg::*;
#(
  parameter int DATA_WIDTH    = 18,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int OUT_REG       = 0
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  FLUSH_i,
  input  logic                  PUSH_i,
  input  logic [DATA_WIDTH-1:0] WDATA_i,
  input  logic                  POP_i,
  output logic [DATA_WIDTH-1:0] RDATA_o,
  output logic                  RVALID_o,
  output logic                  FULL_o,
  output logic                  EMPTY_o,
  output logic                  AFULL_o,
  output logic                  AEMPTY_o,
  output logic [ADDR_WIDTH:0]   COUNT_o,
  output logic                  OVERFLOW_o,
  output logic                  UNDERFLOW_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (!legal_width(DATA_WIDTH)) begin : g_bad_width
    $error("bram_sync_fifo: DATA_WIDTH %0d is not a supported width", DATA_WIDTH);
  end
  if (DATA_WIDTH * DEPTH > BRAM_BITS) begin : g_too_big
    $error("bram_sync_fifo: %0d x %0d exceeds one TDP36K", DATA_WIDTH, DEPTH);
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, udf_q;
  logic                  rd_pend_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  full, empty, push_ok, pop_ok;

  assign full    = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // Acceptance looks only at registered fullness/emptiness, so a pop never
  // makes room for a same-cycle push and a push never feeds a same-cycle pop.
  assign push_ok = PUSH_i & ~full;
  assign pop_ok  = POP_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // The RAM is read on the pop edge; rd_pend_q marks that its output holds
  // a popped word, which the next edge copies into rdata_q with rvalid_q.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else if (FLUSH_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_q | (PUSH_i & full);
      udf_q     <= udf_q | (POP_i & empty);
      rd_pend_q <= pop_ok;
      rvalid_q  <= rd_pend_q;
      if (rd_pend_q) rdata_q <= core_rdata;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  rvalid2_q;
    logic [DATA_WIDTH-1:0] rdata2_q;
    always_ff @(posedge CLK_i) begin
      if (RST_i) begin
        rvalid2_q <= 1'b0;
        rdata2_q  <= '0;
      end else if (FLUSH_i) begin
        rvalid2_q <= 1'b0;
      end else begin
        rvalid2_q <= rvalid_q;
        if (rvalid_q) rdata2_q <= rdata_q;
      end
    end
    assign RVALID_o = rvalid2_q;
    assign RDATA_o  = rdata2_q;
  end else begin : g_no_out_reg
    assign RVALID_o = rvalid_q;
    assign RDATA_o  = rdata_q;
  end

  bram_sdp_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk_i  (CLK_i),
    .we_i   (push_ok & ~FLUSH_i & ~RST_i),
    .waddr_i(wr_ptr_q),
    .wdata_i(WDATA_i),
    .re_i   (pop_ok & ~FLUSH_i & ~RST_i),
    .raddr_i(rd_ptr_q),
    .rdata_o(core_rdata)
  );

  assign FULL_o      = full;
  assign EMPTY_o     = empty;
  assign AFULL_o     = (int'(count_q) >= AFULL_THRESH);
  assign AEMPTY_o    = (int'(count_q) <= AEMPTY_THRESH);
  assign COUNT_o     = count_q;
  assign OVERFLOW_o  = ovf_q;
  assign UNDERFLOW_o = udf_q;

endmodule

// File: tb/tb_bram_sync_fifo.sv
// tb_bram_sync_fifo
// Directed bench for bram_sync_fifo. Instance A is an 18-bit x 16 FIFO
// without output register; instance B is a 9-bit x 16 FIFO with it.
// Inputs change 1 time unit after a rising edge and outputs are checked
// at that same point, i.e. showing the state left by the edge.
module tb_bram_sync_fifo;

  logic        clock;
  logic        reset;

  logic        flushA, pushA, popA;
  logic [17:0] wdataA, rdataA;
  logic        rvalidA, fullA, emptyA, afullA, aemptyA, ovfA, udfA;
  logic [4:0]  countA;

  logic        flushB, pushB, popB;
  logic [8:0]  wdataB, rdataB;
  logic        rvalidB, fullB, emptyB, afullB, aemptyB, ovfB, udfB;
  logic [4:0]  countB;

  int total;
  int bad;

  bram_sync_fifo #(.DATA_WIDTH(18), .ADDR_WIDTH(4), .OUT_REG(0)) dutA (
    .CLK_i(clock), .RST_i(reset), .FLUSH_i(flushA), .PUSH_i(pushA), .WDATA_i(wdataA),
    .POP_i(popA), .RDATA_o(rdataA), .RVALID_o(rvalidA), .FULL_o(fullA), .EMPTY_o(emptyA),
    .AFULL_o(afullA), .AEMPTY_o(aemptyA), .COUNT_o(countA), .OVERFLOW_o(ovfA),
    .UNDERFLOW_o(udfA)
  );

  bram_sync_fifo #(.DATA_WIDTH(9), .ADDR_WIDTH(4), .OUT_REG(1)) dutB (
    .CLK_i(clock), .RST_i(reset), .FLUSH_i(flushB), .PUSH_i(pushB), .WDATA_i(wdataB),
    .POP_i(popB), .RDATA_o(rdataB), .RVALID_o(rvalidB), .FULL_o(fullB), .EMPTY_o(emptyB),
    .AFULL_o(afullB), .AEMPTY_o(aemptyB), .COUNT_o(countB), .OVERFLOW_o(ovfB),
    .UNDERFLOW_o(udfB)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (countA !== 5'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", countA); end
    total++; if (emptyA !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b want 1", emptyA); end
    total++; if (aemptyA !== 1'b1) begin bad++; $display("[TB] FAIL reset_aempty: got %b want 1", aemptyA); end
    total++; if (fullA !== 1'b0) begin bad++; $display("[TB] FAIL reset_full: got %b want 0", fullA); end
    total++; if (afullA !== 1'b0) begin bad++; $display("[TB] FAIL reset_afull: got %b want 0", afullA); end
    total++; if (rvalidA !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalidA); end
    total++; if (rdataA !== 18'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %0h want 0", rdataA); end
    total++; if ({ovfA, udfA} !== 2'b00) begin bad++; $display("[TB] FAIL reset_sticky: got %b want 00", {ovfA, udfA}); end
    total++; if (rdataB !== 9'h0 || rvalidB !== 1'b0) begin bad++; $display("[TB] FAIL reset_b_out: got %0h/%b want 0/0", rdataB, rvalidB); end
  endtask

  // Fill to full, watching the almost flags cross their thresholds, then overflow.
  task automatic test_fill_overflow();
    for (int i = 1; i <= 16; i++) begin
      pushA = 1'b1;
      wdataA = 18'(i);
      tick();
      if (i == 4) begin total++; if (aemptyA !== 1'b1) begin bad++; $display("[TB] FAIL aempty_at4: got %b want 1", aemptyA); end end
      if (i == 5) begin total++; if (aemptyA !== 1'b0) begin bad++; $display("[TB] FAIL aempty_at5: got %b want 0", aemptyA); end end
      if (i == 11) begin total++; if (afullA !== 1'b0) begin bad++; $display("[TB] FAIL afull_at11: got %b want 0", afullA); end end
      if (i == 12) begin total++; if (afullA !== 1'b1) begin bad++; $display("[TB] FAIL afull_at12: got %b want 1", afullA); end end
    end
    pushA = 1'b0;
    total++; if (countA !== 5'd16) begin bad++; $display("[TB] FAIL fill_count: got %0d want 16", countA); end
    total++; if (fullA !== 1'b1) begin bad++; $display("[TB] FAIL fill_full: got %b want 1", fullA); end
    total++; if (ovfA !== 1'b0) begin bad++; $display("[TB] FAIL fill_no_ovf: got %b want 0", ovfA); end
    pushA = 1'b1;
    wdataA = 18'h3FFFF;
    tick();
    pushA = 1'b0;
    total++; if (ovfA !== 1'b1) begin bad++; $display("[TB] FAIL overflow_flag: got %b want 1", ovfA); end
    total++; if (countA !== 5'd16) begin bad++; $display("[TB] FAIL overflow_count: got %0d want 16", countA); end
  endtask

  // Back-to-back pops: each word appears with RVALID one edge after the pop edge.
  task automatic test_drain_underflow();
    for (int i = 0; i <= 17; i++) begin
      popA = (i < 16);
      tick();
      if (i == 0) begin
        total++; if (rvalidA !== 1'b0) begin bad++; $display("[TB] FAIL drain_first_latency: got %b want 0", rvalidA); end
        total++; if (fullA !== 1'b0) begin bad++; $display("[TB] FAIL drain_not_full: got %b want 0", fullA); end
      end else if (i <= 16) begin
        total++; if (rvalidA !== 1'b1 || rdataA !== 18'(i)) begin bad++; $display("[TB] FAIL drain_word%0d: got %b/%0h want 1/%0h", i, rvalidA, rdataA, i); end
      end else begin
        total++; if (rvalidA !== 1'b0 || rdataA !== 18'd16) begin bad++; $display("[TB] FAIL drain_hold: got %b/%0h want 0/10", rvalidA, rdataA); end
      end
      if (i == 8) begin total++; if (countA !== 5'd7) begin bad++; $display("[TB] FAIL drain_count: got %0d want 7", countA); end end
    end
    popA = 1'b0;
    total++; if (emptyA !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty: got %b want 1", emptyA); end
    total++; if (udfA !== 1'b0) begin bad++; $display("[TB] FAIL drain_no_udf: got %b want 0", udfA); end
    popA = 1'b1;
    tick();
    popA = 1'b0;
    total++; if (udfA !== 1'b1) begin bad++; $display("[TB] FAIL underflow_flag: got %b want 1", udfA); end
    total++; if (countA !== 5'd0) begin bad++; $display("[TB] FAIL underflow_count: got %0d want 0", countA); end
    tick();
    total++; if (rvalidA !== 1'b0) begin bad++; $display("[TB] FAIL underflow_no_rvalid: got %b want 0", rvalidA); end
  endtask

  // Steady-state push+pop at count 5, then the same pair on an empty FIFO.
  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) begin
      pushA = 1'b1;
      wdataA = 18'(100 + i);
      tick();
    end
    for (int k = 0; k < 100; k++) begin
      pushA = 1'b1;
      popA = 1'b1;
      wdataA = 18'(105 + k);
      tick();
      total++; if (countA !== 5'd5) begin bad++; $display("[TB] FAIL simul_count_k%0d: got %0d want 5", k, countA); end
      if (k >= 1) begin
        total++; if (rvalidA !== 1'b1 || rdataA !== 18'(99 + k)) begin bad++; $display("[TB] FAIL simul_data_k%0d: got %b/%0d want 1/%0d", k, rvalidA, rdataA, 99 + k); end
      end
    end
    pushA = 1'b0;
    popA = 1'b0;
    tick();
    total++; if (rvalidA !== 1'b1 || rdataA !== 18'd199) begin bad++; $display("[TB] FAIL simul_last: got %b/%0d want 1/199", rvalidA, rdataA); end
    popA = 1'b1;
    repeat (5) tick();
    popA = 1'b0;
    tick();
    tick();
    total++; if (countA !== 5'd0 || rdataA !== 18'd204) begin bad++; $display("[TB] FAIL simul_drain: got %0d/%0d want 0/204", countA, rdataA); end
    pushA = 1'b1;
    popA = 1'b1;
    wdataA = 18'h2AAAA;
    tick();
    pushA = 1'b0;
    popA = 1'b0;
    total++; if (countA !== 5'd1) begin bad++; $display("[TB] FAIL empty_pair_count: got %0d want 1", countA); end
    tick();
    total++; if (rvalidA !== 1'b0) begin bad++; $display("[TB] FAIL empty_pair_rvalid: got %b want 0", rvalidA); end
    popA = 1'b1;
    tick();
    popA = 1'b0;
    tick();
    total++; if (rvalidA !== 1'b1 || rdataA !== 18'h2AAAA) begin bad++; $display("[TB] FAIL empty_pair_word: got %b/%0h want 1/2aaaa", rvalidA, rdataA); end
  endtask

  // Flush with a pop in flight and a sticky overflow; then reset clears stickies.
  task automatic test_flush();
    for (int i = 0; i < 8; i++) begin
      pushA = 1'b1;
      wdataA = 18'(12'h300 + i);
      tick();
    end
    pushA = 1'b0;
    popA = 1'b1;
    tick();
    popA = 1'b0;
    total++; if (countA !== 5'd7 || ovfA !== 1'b1) begin bad++; $display("[TB] FAIL preflush_state: got %0d/%b want 7/1", countA, ovfA); end
    flushA = 1'b1;
    tick();
    flushA = 1'b0;
    total++; if (countA !== 5'd0 || emptyA !== 1'b1) begin bad++; $display("[TB] FAIL flush_count: got %0d/%b want 0/1", countA, emptyA); end
    total++; if (rvalidA !== 1'b0) begin bad++; $display("[TB] FAIL flush_squash: got %b want 0", rvalidA); end
    total++; if (rdataA !== 18'h2AAAA) begin bad++; $display("[TB] FAIL flush_rdata_hold: got %0h want 2aaaa", rdataA); end
    total++; if (ovfA !== 1'b1) begin bad++; $display("[TB] FAIL flush_keeps_ovf: got %b want 1", ovfA); end
    tick();
    total++; if (rvalidA !== 1'b0) begin bad++; $display("[TB] FAIL flush_squash_late: got %b want 0", rvalidA); end
    pushA = 1'b1;
    wdataA = 18'h00155;
    tick();
    pushA = 1'b0;
    popA = 1'b1;
    tick();
    popA = 1'b0;
    tick();
    total++; if (rvalidA !== 1'b1 || rdataA !== 18'h00155) begin bad++; $display("[TB] FAIL postflush_word: got %b/%0h want 1/155", rvalidA, rdataA); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({ovfA, udfA} !== 2'b00) begin bad++; $display("[TB] FAIL reset_clears_sticky: got %b want 00", {ovfA, udfA}); end
    total++; if (rdataA !== 18'h0 || countA !== 5'd0) begin bad++; $display("[TB] FAIL reset_after_flush: got %0h/%0d want 0/0", rdataA, countA); end
  endtask

  // 9-bit lane packing with the output register: two-edge latency per pop.
  task automatic test_x9_outreg();
    pushB = 1'b1;
    wdataB = 9'h1A5;
    tick();
    wdataB = 9'h05A;
    tick();
    pushB = 1'b0;
    total++; if (countB !== 5'd2) begin bad++; $display("[TB] FAIL x9_count: got %0d want 2", countB); end
    popB = 1'b1;
    tick();
    tick();
    popB = 1'b0;
    total++; if (rvalidB !== 1'b0) begin bad++; $display("[TB] FAIL x9_latency: got %b want 0", rvalidB); end
    tick();
    total++; if (rvalidB !== 1'b1 || rdataB !== 9'h1A5) begin bad++; $display("[TB] FAIL x9_word0: got %b/%0h want 1/1a5", rvalidB, rdataB); end
    tick();
    total++; if (rvalidB !== 1'b1 || rdataB !== 9'h05A) begin bad++; $display("[TB] FAIL x9_word1: got %b/%0h want 1/5a", rvalidB, rdataB); end
    tick();
    total++; if (rvalidB !== 1'b0 || rdataB !== 9'h05A) begin bad++; $display("[TB] FAIL x9_hold: got %b/%0h want 0/5a", rvalidB, rdataB); end
  endtask

  // Scenario sequence and final summary.
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    flushA = 1'b0; pushA = 1'b0; popA = 1'b0; wdataA = '0;
    flushB = 1'b0; pushB = 1'b0; popB = 1'b0; wdataB = '0;
    $display("[TB] starting bram_sync_fifo scenarios");
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simultaneous();
    test_flush();
    test_x9_outreg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
